// File: rtl/light_seq_monitor_pkg.sv
// Shared encodings for the traffic-light sequencer and its downstream monitor.
package light_seq_monitor_pkg;

  localparam logic [1:0] COL_RED = 2'b00;
  localparam logic [1:0] COL_YEL = 2'b10;
  localparam logic [1:0] COL_GRN = 2'b01;
  localparam logic [1:0] COL_ILL = 2'b11;

  localparam logic [2:0] ACT_RED = 3'b011;
  localparam logic [2:0] ACT_YEL = 3'b100;
  localparam logic [2:0] ACT_GRN = 3'b101;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_ACT  = 2'b10;
  localparam logic [1:0] ERR_SEQ  = 2'b11;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_EXP_Y1,
    ST_EXP_G1,
    ST_EXP_Y2,
    ST_EXP_G2,
    ST_EXP_R
  } mon_state_e;

  // The illegal colour maps to an action code the sequencer never emits.
  function automatic logic [2:0] exp_action(input logic [1:0] color);
    case (color)
      COL_RED: exp_action = ACT_RED;
      COL_YEL: exp_action = ACT_YEL;
      COL_GRN: exp_action = ACT_GRN;
      default: exp_action = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/light_fail_blink.sv
// Fail-safe flasher: high on start, then toggles every BLINK_HALF cycles until stop.
module light_fail_blink #(
  parameter int BLINK_HALF = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic stop,
  output logic blink
);
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt;
  logic          run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      run   <= 1'b0;
      blink <= 1'b1;
    end else if (stop) begin
      cnt   <= '0;
      run   <= 1'b0;
      blink <= 1'b1;
    end else if (start) begin
      cnt   <= '0;
      run   <= 1'b1;
      blink <= 1'b1;
    end else if (run) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        blink <= ~blink;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/light_seq_monitor.sv
// Checks the sequencer colour/action stream, counts RED-to-RED cycles and drives
// the lamps, falling back to a flashing red on the first fault until cleared.
module light_seq_monitor
  import light_seq_monitor_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int BLINK_HALF = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       color,
  input  logic [2:0]       action,
  output logic             lamp_r,
  output logic             lamp_y,
  output logic             lamp_g,
  output logic             seq_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             locked
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mon_state_e state, state_nxt;
  logic       illegal, mismatch, good, seq_bad, fault, wrap, blink_start, blink;
  logic [1:0] want, fault_code;
  logic [2:0] lamp_q;

  always_comb begin
    illegal  = (color == COL_ILL);
    mismatch = !illegal && (action != exp_action(color));
    good     = !illegal && !mismatch;
    case (state)
      ST_EXP_Y1, ST_EXP_Y2: want = COL_YEL;
      ST_EXP_G1, ST_EXP_G2: want = COL_GRN;
      default:              want = COL_RED;
    endcase
    seq_bad = good && (state != ST_HUNT) && (color != want);

    fault_code = ERR_NONE;
    if (illegal)       fault_code = ERR_ILL;
    else if (mismatch) fault_code = ERR_ACT;
    else if (seq_bad)  fault_code = ERR_SEQ;
    fault = en && (fault_code != ERR_NONE);
    wrap  = en && !fault && (state == ST_EXP_R);

    state_nxt = state;
    if (clear || fault) begin
      state_nxt = ST_HUNT;
    end else if (en) begin
      case (state)
        ST_HUNT:   if (color == COL_RED) state_nxt = ST_EXP_Y1;
        ST_EXP_Y1: state_nxt = ST_EXP_G1;
        ST_EXP_G1: state_nxt = ST_EXP_Y2;
        ST_EXP_Y2: state_nxt = ST_EXP_G2;
        ST_EXP_G2: state_nxt = ST_EXP_R;
        default:   state_nxt = ST_EXP_Y1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_HUNT;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_err   <= 1'b0;
      err_code  <= ERR_NONE;
      cycle_cnt <= '0;
      lamp_q    <= 3'b100;
    end else if (clear) begin
      seq_err   <= 1'b0;
      err_code  <= ERR_NONE;
      cycle_cnt <= '0;
      lamp_q    <= 3'b100;
    end else if (fault) begin
      seq_err <= 1'b1;
      if (!seq_err) err_code <= fault_code;
    end else if (en) begin
      if (wrap && cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
      lamp_q <= {color == COL_RED, color == COL_YEL, color == COL_GRN};
    end
  end

  // Only the first fault restarts the flash phase; later faults leave it running.
  assign blink_start = fault && !seq_err && !clear;

  light_fail_blink #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (blink_start),
    .stop    (clear),
    .blink   (blink)
  );

  assign lamp_r = seq_err ? blink : lamp_q[2];
  assign lamp_y = lamp_q[1] & ~seq_err;
  assign lamp_g = lamp_q[0] & ~seq_err;
  assign locked = (state != ST_HUNT);

endmodule

// File: doc/light_seq_monitor.md
Name: light_seq_monitor

Overview:
- Downstream consumer of the traffic-light sequencer. Samples its color/action outputs each enabled cycle and drives the three physical lamp lines from them.
- Checks the stream against the legal phase order RED, Y1, G1, Y2, G2, RED and checks color/action consistency.
- Counts completed cycles.
- On any fault, latches a sticky error and forces a fail-safe flashing-red lamp pattern until cleared.

Parameters:
- CNT_W, 16, width of completed-cycle counter (saturating).
- BLINK_HALF, 4, cycles per half-period of fail-safe red flash (>=1).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  sample enable; 0 = hold all state except blink logic
- clear  in  1  synchronous clear of error, counter, FSM
- color  in  2  sequencer color: 00 red, 10 yellow, 01 green, 11 illegal
- action  in  3  sequencer action: 011 red, 100 yellow, 101 green
- lamp_r  out  1  red lamp drive
- lamp_y  out  1  yellow lamp drive
- lamp_g  out  1  green lamp drive
- seq_err  out  1  sticky fault flag
- err_code  out  2  first fault cause: 00 none, 01 illegal color, 10 action mismatch, 11 sequence violation
- cycle_cnt  out  CNT_W  completed RED-to-RED cycles, saturating
- locked  out  1  1 when monitor is synchronised to the sequence (FSM not in HUNT)

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All outputs registered.
- Reset values: lamp_r=1, lamp_y=0, lamp_g=0, seq_err=0, err_code=00, cycle_cnt=0, locked=0, FSM=HUNT, blink counter=0.
- Latency: inputs sampled at posedge; all outputs reflect that sample after the same edge (1-cycle latency).
- FSM states: HUNT, EXP_Y1, EXP_G1, EXP_Y2, EXP_G2, EXP_R.
- Good sample: color!=11 and action matches color.
- HUNT:
  - good RED -> EXP_Y1.
  - good Y or G -> stay in HUNT, no error.
- Locked states:
  - EXP_Y1 needs Y -> EXP_G1.
  - EXP_G1 needs G -> EXP_Y2.
  - EXP_Y2 needs Y -> EXP_G2.
  - EXP_G2 needs G -> EXP_R.
  - EXP_R needs R -> EXP_Y1 and cycle_cnt+1 (holds at all-ones).
- Fault priority per sample: illegal color (01) > action mismatch (10) > sequence violation (11, locked states only).
- On a fault:
  - seq_err<=1; err_code loaded only if seq_err was 0 (first cause kept).
  - FSM<=HUNT.
- Once in HUNT after a fault, the monitor keeps checking: it resyncs on the next good RED, and later faults do not overwrite err_code.
- Lamp drive, seq_err=0 and en=1: one-hot from the sampled good color (R->lamp_r, Y->lamp_y, G->lamp_g).
- Lamp drive, seq_err=1 (fail-safe):
  - lamp_y=lamp_g=0.
  - lamp_r=1 on the fault edge; blink counter then runs 0..BLINK_HALF-1 and toggles lamp_r at each wrap.
  - Blink runs regardless of en.
- en=0: no sampling, FSM, counter and lamps hold (except fail-safe blink); inputs ignored, including illegal values.
- clear=1: priority over en and sampling.
  - seq_err=0, err_code=00, cycle_cnt=0, FSM=HUNT, blink counter=0.
  - Lamps: lamp_r=1, lamp_y=0, lamp_g=0.
  - That cycle's input is discarded.
- Reset mid-operation: immediate return to reset values regardless of clk.
- cycle_cnt saturation: at 2^CNT_W-1 a further RED in EXP_R keeps the value and the FSM still advances.

Decomposition:
- Shared package holds:
  - color encodings (RED 00, YEL 10, GRN 01) and action encodings (011/100/101);
  - err_code constants;
  - the monitor state enum;
  - a color-to-expected-action function reused by the sequencer and the monitor.
- One sub-module: light_fail_blink. Inputs: clk, reset_n, start, stop. Output: blink. Parameter: BLINK_HALF.

Test Plan:
- Legal stream, en=1: reset, then R,Y,G,Y,G,R,Y,G,Y,G,R with matching actions -> cycle_cnt=2, locked=1 from first edge, seq_err=0, lamps one-hot tracking color with 1-cycle latency.
- Sequence violation: after lock, drive R,Y,Y (second Y where G expected) -> seq_err=1 and err_code=11 on third edge, locked=0. Then feed R,Y,G,Y -> locked=1 and err_code stays 11.
- Action mismatch and illegal color:
  - color=01 with action=100 -> err_code=10.
  - Separate run, color=11 with action=100 -> err_code=01, since illegal color outranks mismatch.
- Fail-safe blink, BLINK_HALF=4: after fault, lamp_r=1 for 4 cycles, then 0 for 4, repeating; lamp_y=lamp_g=0 throughout, including with en=0.
- clear and saturation:
  - CNT_W=2: run 4 full cycles -> cycle_cnt stays 3.
  - Assert clear with a fault pending -> next edge cycle_cnt=0, seq_err=0, err_code=00, lamp_r=1, locked=0.
- Async reset mid-cycle: while in EXP_G1, pulse reset_n low between edges -> outputs at reset values immediately, and monitor relocks on next RED.
